// File: rtl/clock_set_pkg.sv
// rtl/clock_set_pkg.sv - shared types and constants for the clock/date setter
// Purpose: field and state enums, field limits, reset year and leap-year helper.
// Ports: none (package).
package clock_set_pkg;

    typedef enum logic [2:0] {
        FIELD_HOUR  = 3'd0,
        FIELD_MIN   = 3'd1,
        FIELD_SEC   = 3'd2,
        FIELD_DAY   = 3'd3,
        FIELD_MONTH = 3'd4,
        FIELD_YEAR  = 3'd5
    } field_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [5:0]  SEC_MAX    = 6'd59;
    localparam logic [5:0]  MIN_MAX    = 6'd59;
    localparam logic [4:0]  HOUR_MAX   = 5'd23;
    localparam logic [3:0]  MONTH_MAX  = 4'd12;
    localparam logic [13:0] RESET_YEAR = 14'd2024;

    // Same rule as the calendar counter: every fourth year is a leap year.
    function automatic logic is_leap(input logic [13:0] year);
        return (year[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - button/live-time/shadow-time bundle for clock_set_ctrl
// Purpose: groups the button pulses, live time inputs and the setter outputs.
// Ports (signals):
//   btn_mode/btn_next/btn_inc  one-cycle button pulses
//   cur_*                      live time/date from the calendar counter
//   set_*, load                shadow time/date and its one-cycle load strobe
//   editing, field_sel, blink  edit status for the display
// Modports: master (button/time source side), slave (clock_set_ctrl side).
interface clock_set_ctrl_if;

    logic        btn_mode;
    logic        btn_next;
    logic        btn_inc;

    logic [5:0]  cur_sec;
    logic [5:0]  cur_min;
    logic [4:0]  cur_hour;
    logic [4:0]  cur_day;
    logic [3:0]  cur_month;
    logic [13:0] cur_year;

    logic [5:0]  set_sec;
    logic [5:0]  set_min;
    logic [4:0]  set_hour;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [13:0] set_year;

    logic        load;
    logic        editing;
    logic [2:0]  field_sel;
    logic        blink;

    modport master (
        output btn_mode, btn_next, btn_inc,
        output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        input  set_sec, set_min, set_hour, set_day, set_month, set_year,
        input  load, editing, field_sel, blink
    );

    modport slave (
        input  btn_mode, btn_next, btn_inc,
        input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        output set_sec, set_min, set_hour, set_day, set_month, set_year,
        output load, editing, field_sel, blink
    );

endinterface

// File: rtl/days_in_month.sv
// rtl/days_in_month.sv - combinational days-in-month lookup
// Purpose: number of days in a month, leap-aware; shared with the calendar counter.
// Ports:
//   month  in  4   month 1..12 (out-of-range months report 31)
//   year   in  14  year, only its leap status matters
//   dim    out 5   days in that month
module days_in_month
    import clock_set_pkg::*;
(
    input  logic [3:0]  month,
    input  logic [13:0] year,
    output logic [4:0]  dim
);

    always_comb begin
        dim = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - button-driven time/date setter feeding the calendar load port
// Purpose: captures live time on entry, edits one field at a time with calendar-legal
//          wrap and day clamping, then issues a one-cycle load strobe.
// Optional feature macro: CLOCK_SET_BLINK_EN (blink counter for the selected field).
// Ports:
//   clk    in  1   system clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    clock_set_ctrl_if.slave: buttons, cur_* in; set_*, load, editing,
//          field_sel, blink out
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int unsigned YEAR_MAX  = 9999,
    parameter int unsigned BLINK_DIV = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    clock_set_ctrl_if.slave    bus
);

    localparam logic [13:0] YEAR_TOP = 14'(YEAR_MAX);

    state_e      state;
    field_e      field;
    logic        load_q;
    logic        editing_q;

    logic [5:0]  sec_q;
    logic [5:0]  min_q;
    logic [4:0]  hour_q;
    logic [4:0]  day_q;
    logic [3:0]  month_q;
    logic [13:0] year_q;

    // Incremented candidates; ">=" lets out-of-range captures wrap on first inc.
    logic [5:0]  sec_inc;
    logic [5:0]  min_inc;
    logic [4:0]  hour_inc;
    logic [4:0]  day_inc;
    logic [3:0]  month_inc;
    logic [13:0] year_inc;
    logic [4:0]  day_clamped;

    assign sec_inc   = (sec_q   >= SEC_MAX)   ? 6'd0  : sec_q + 6'd1;
    assign min_inc   = (min_q   >= MIN_MAX)   ? 6'd0  : min_q + 6'd1;
    assign hour_inc  = (hour_q  >= HOUR_MAX)  ? 5'd0  : hour_q + 5'd1;
    assign month_inc = (month_q >= MONTH_MAX) ? 4'd1  : month_q + 4'd1;
    assign year_inc  = (year_q  >= YEAR_TOP)  ? 14'd0 : year_q + 14'd1;

    // One lookup serves all three uses: when MONTH or YEAR is selected it sees
    // the post-increment date, so the clamp lands on the same edge as the inc;
    // otherwise it sees the current date, which is what the day wrap needs.
    logic [3:0]  dim_month;
    logic [13:0] dim_year;
    logic [4:0]  dim;

    assign dim_month = (field == FIELD_MONTH) ? month_inc : month_q;
    assign dim_year  = (field == FIELD_YEAR)  ? year_inc  : year_q;

    days_in_month u_dim (
        .month (dim_month),
        .year  (dim_year),
        .dim   (dim)
    );

    assign day_inc     = (day_q >= dim) ? 5'd1 : day_q + 5'd1;
    assign day_clamped = (day_q >  dim) ? dim  : day_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            field     <= FIELD_HOUR;
            load_q    <= 1'b0;
            editing_q <= 1'b0;
            sec_q     <= 6'd0;
            min_q     <= 6'd0;
            hour_q    <= 5'd0;
            day_q     <= 5'd1;
            month_q   <= 4'd1;
            year_q    <= RESET_YEAR;
        end else begin
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.btn_mode) begin
                        sec_q     <= bus.cur_sec;
                        min_q     <= bus.cur_min;
                        hour_q    <= bus.cur_hour;
                        day_q     <= bus.cur_day;
                        month_q   <= bus.cur_month;
                        year_q    <= bus.cur_year;
                        field     <= FIELD_HOUR;
                        editing_q <= 1'b1;
                        state     <= EDIT;
                    end
                end
                EDIT: begin
                    // Priority mode > next > inc; lower pulses in the same cycle are dropped.
                    if (bus.btn_mode) begin
                        editing_q <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.btn_next) begin
                        if (field == FIELD_YEAR) begin
                            editing_q <= 1'b0;
                            load_q    <= 1'b1;
                            state     <= COMMIT;
                        end else begin
                            field <= field_e'(field + 3'd1);
                        end
                    end else if (bus.btn_inc) begin
                        case (field)
                            FIELD_HOUR: hour_q <= hour_inc;
                            FIELD_MIN:  min_q  <= min_inc;
                            FIELD_SEC:  sec_q  <= sec_inc;
                            FIELD_DAY:  day_q  <= day_inc;
                            FIELD_MONTH: begin
                                month_q <= month_inc;
                                day_q   <= day_clamped;
                            end
                            default: begin
                                year_q <= year_inc;
                                day_q  <= day_clamped;
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    // load_q was raised on entry and drops here: exactly one cycle.
                    state <= IDLE;
                end
                default: begin
                    editing_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.set_sec   = sec_q;
    assign bus.set_min   = min_q;
    assign bus.set_hour  = hour_q;
    assign bus.set_day   = day_q;
    assign bus.set_month = month_q;
    assign bus.set_year  = year_q;
    assign bus.load      = load_q;
    assign bus.editing   = editing_q;
    assign bus.field_sel = field;

`ifdef CLOCK_SET_BLINK_EN
    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] blink_cnt;
    logic          blink_q;
    logic          blink_restart;

    // Any field move or inc restarts the phase so the edited field is shown at once.
    assign blink_restart = (state != EDIT) || bus.btn_mode || bus.btn_next || bus.btn_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_restart) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bus.blink = blink_q;
`else
    assign bus.blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard testbench for clock_set_ctrl
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus ();

    clock_set_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int   due;
        logic ed;
        int   fs, h, mi, s, d, mo, y;
        logic ld;
    } exp_t;

    typedef struct {
        int h, mi, s, d, mo, y;
    } ld_t;

    exp_t exp_q[$];
    ld_t  load_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_state(input logic ed, input int fs, h, mi, s, d, mo, y, input logic ld);
        exp_t e;
        e.due = cyc; e.ed = ed; e.fs = fs; e.h = h; e.mi = mi; e.s = s;
        e.d = d; e.mo = mo; e.y = y; e.ld = ld;
        exp_q.push_back(e);
    endtask

    task automatic exp_load(input int h, mi, s, d, mo, y);
        ld_t l;
        l.h = h; l.mi = mi; l.s = s; l.d = d; l.mo = mo; l.y = y;
        load_q.push_back(l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse for one cycle; returns 1 time unit after the sampling edge.
    task automatic press(input logic m, input logic n, input logic i);
        @(posedge clk);
        #1;
        bus.btn_mode = m;
        bus.btn_next = n;
        bus.btn_inc  = i;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic set_cur(input int h, mi, s, d, mo, y);
        bus.cur_hour  = 5'(h);
        bus.cur_min   = 6'(mi);
        bus.cur_sec   = 6'(s);
        bus.cur_day   = 5'(d);
        bus.cur_month = 4'(mo);
        bus.cur_year  = 14'(y);
    endtask

    // Monitor: compares queued expectations at their cycle, and every load strobe.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                logic ok;
                e = exp_q.pop_front();
                ok = (e.due == cyc) && (bus.editing == e.ed) && (int'(bus.field_sel) == e.fs) &&
                     (int'(bus.set_hour) == e.h) && (int'(bus.set_min) == e.mi) &&
                     (int'(bus.set_sec) == e.s) && (int'(bus.set_day) == e.d) &&
                     (int'(bus.set_month) == e.mo) && (int'(bus.set_year) == e.y) &&
                     (bus.load == e.ld);
`ifndef CLOCK_SET_BLINK_EN
                ok = ok && (bus.blink == 1'b0);
`endif
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL state@cyc%0d got ed=%0d fs=%0d %0d:%0d:%0d %0d/%0d/%0d ld=%0d bl=%0d, want ed=%0d fs=%0d %0d:%0d:%0d %0d/%0d/%0d ld=%0d (due %0d)",
                             cyc, bus.editing, bus.field_sel, bus.set_hour, bus.set_min, bus.set_sec,
                             bus.set_day, bus.set_month, bus.set_year, bus.load, bus.blink,
                             e.ed, e.fs, e.h, e.mi, e.s, e.d, e.mo, e.y, e.ld, e.due);
                end
            end
            if (bus.load) begin
                checks++;
                if (load_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_unexpected@cyc%0d got load=1 want load=0", cyc);
                end else begin
                    ld_t l;
                    l = load_q.pop_front();
                    if (int'(bus.set_hour) != l.h || int'(bus.set_min) != l.mi ||
                        int'(bus.set_sec) != l.s || int'(bus.set_day) != l.d ||
                        int'(bus.set_month) != l.mo || int'(bus.set_year) != l.y) begin
                        errors++;
                        $display("FAIL load_data@cyc%0d got %0d:%0d:%0d %0d/%0d/%0d want %0d:%0d:%0d %0d/%0d/%0d",
                                 cyc, bus.set_hour, bus.set_min, bus.set_sec, bus.set_day,
                                 bus.set_month, bus.set_year, l.h, l.mi, l.s, l.d, l.mo, l.y);
                    end
                end
            end
        end
    end

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_inc  = 1'b0;
        set_cur(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        exp_state(0, 0, 0, 0, 0, 1, 1, 2024, 0);

        // next/inc ignored in IDLE
        press(0, 1, 1);
        exp_state(0, 0, 0, 0, 0, 1, 1, 2024, 0);

        // Capture on entry
        set_cur(12, 34, 56, 15, 6, 2030);
        press(1, 0, 0);
        exp_state(1, 0, 12, 34, 56, 15, 6, 2030, 0);
        press(1, 0, 0);
        exp_state(0, 0, 12, 34, 56, 15, 6, 2030, 0);

        // Hour 23 wraps to 0, then counts on
        set_cur(23, 34, 56, 15, 6, 2030);
        press(1, 0, 0);
        exp_state(1, 0, 23, 34, 56, 15, 6, 2030, 0);
        press(0, 0, 1);
        exp_state(1, 0, 0, 34, 56, 15, 6, 2030, 0);
        press(0, 0, 1);
        exp_state(1, 0, 1, 34, 56, 15, 6, 2030, 0);
        press(1, 0, 0);
        exp_state(0, 0, 1, 34, 56, 15, 6, 2030, 0);

        // 31 Jan 2023 -> Feb clamps day to 28
        set_cur(0, 0, 0, 31, 1, 2023);
        press(1, 0, 0);
        exp_state(1, 0, 0, 0, 0, 31, 1, 2023, 0);
        repeat (4) press(0, 1, 0);
        exp_state(1, 4, 0, 0, 0, 31, 1, 2023, 0);
        press(0, 0, 1);
        exp_state(1, 4, 0, 0, 0, 28, 2, 2023, 0);
        press(1, 0, 0);
        exp_state(0, 4, 0, 0, 0, 28, 2, 2023, 0);

        // 31 Jan 2024 -> Feb 29; year 2025 clamps to 28; commit
        set_cur(0, 0, 0, 31, 1, 2024);
        press(1, 0, 0);
        exp_state(1, 0, 0, 0, 0, 31, 1, 2024, 0);
        repeat (4) press(0, 1, 0);
        press(0, 0, 1);
        exp_state(1, 4, 0, 0, 0, 29, 2, 2024, 0);
        press(0, 1, 0);
        exp_state(1, 5, 0, 0, 0, 29, 2, 2024, 0);
        press(0, 0, 1);
        exp_state(1, 5, 0, 0, 0, 28, 2, 2025, 0);
        exp_load(0, 0, 0, 28, 2, 2025);
        press(0, 1, 0);
        exp_state(0, 5, 0, 0, 0, 28, 2, 2025, 1);
        tick();
        exp_state(0, 5, 0, 0, 0, 28, 2, 2025, 0);

        // Wraps: min 59, out-of-range sec 63, day 30/Apr, year max
        set_cur(5, 59, 63, 30, 4, 9999);
        press(1, 0, 0);
        exp_state(1, 0, 5, 59, 63, 30, 4, 9999, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        exp_state(1, 1, 5, 0, 63, 30, 4, 9999, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        exp_state(1, 2, 5, 0, 0, 30, 4, 9999, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        exp_state(1, 3, 5, 0, 0, 1, 4, 9999, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        exp_state(1, 4, 5, 0, 0, 1, 5, 9999, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        exp_state(1, 5, 5, 0, 0, 1, 5, 0, 0);

        // All three together: abort wins, nothing else changes, no load
        press(1, 1, 1);
        exp_state(0, 5, 5, 0, 0, 1, 5, 0, 0);

        // next beats inc
        press(1, 0, 0);
        exp_state(1, 0, 5, 59, 63, 30, 4, 9999, 0);
        press(0, 1, 1);
        exp_state(1, 1, 5, 59, 63, 30, 4, 9999, 0);

        // Reset while in COMMIT: load drops at once, no strobe seen
        repeat (4) press(0, 1, 0);
        exp_state(1, 5, 5, 59, 63, 30, 4, 9999, 0);
        press(0, 1, 0);
        rst_n = 1'b0;
        exp_state(0, 0, 0, 0, 0, 1, 1, 2024, 0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_state(0, 0, 0, 0, 0, 1, 1, 2024, 0);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0 || load_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending_state=%0d pending_load=%0d want 0 and 0",
                     exp_q.size(), load_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
